// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Parametrised raster timing generator for the HDMI/TMDS output path.
//   Produces zero-latency pixel-request coordinates for the pixel pipeline,
//   plus de/hsync/vsync delayed by PIPE_LAT cycles so they line up with that
//   pipeline's output. Start/stop control drains the current frame before
//   going idle; a frame counter and line/frame strobes are provided.
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   enable              level; 1 = generate frames
//   req_x, req_y        current pixel column / line
//   req_de              request-side active-video flag
//   line_start          strobe at x == 0 while not idle
//   frame_start         strobe at (0,0) while not idle
//   de, hsync, vsync    PIPE_LAT-delayed video timing (sync polarity per *_POL)
//   frame_count         completed frames, wraps silently
//   busy                generator not idle
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned PIPE_LAT = 1,
    parameter int unsigned CW       = 10,
    parameter int unsigned FC_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    output logic [CW-1:0]   req_x,
    output logic [CW-1:0]   req_y,
    output logic            req_de,
    output logic            line_start,
    output logic            frame_start,
    output logic            de,
    output logic            hsync,
    output logic            vsync,
    output logic [FC_W-1:0] frame_count,
    output logic            busy
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_cw_check
        $error("video_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits");
    end
    if (PIPE_LAT == 0 || PIPE_LAT > 16) begin : g_lat_check
        $error("video_timing_gen: PIPE_LAT must be in 1..16");
    end

    localparam logic [CW-1:0]   X_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]   Y_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
    // Window bounds carry one extra bit so an end bound equal to 2^CW stays exact.
    localparam logic [CW:0] X_ACT    = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] Y_ACT    = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] HS_BEGIN = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] VS_BEGIN = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   x_q, x_d, y_q, y_d;
    logic [FC_W-1:0] fc_q, fc_d;

    // Each pipe stage holds {vsync_active, hsync_active, de}.
    logic [PIPE_LAT-1:0][2:0] pipe_q, pipe_d;
    logic [2:0]               stage_in;

    logic          active, last_x, last_y;
    logic [CW:0]   x_ext, y_ext;
    logic          hs_win, vs_win;

    assign active = (state_q != S_IDLE);
    assign last_x = (x_q == X_LAST);
    assign last_y = (y_q == Y_LAST);
    assign x_ext  = {1'b0, x_q};
    assign y_ext  = {1'b0, y_q};
    assign hs_win = (x_ext >= HS_BEGIN) && (x_ext < HS_END);
    assign vs_win = (y_ext >= VS_BEGIN) && (y_ext < VS_END);

    assign req_x       = x_q;
    assign req_y       = y_q;
    assign req_de      = active && (x_ext < X_ACT) && (y_ext < Y_ACT);
    assign line_start  = active && (x_q == '0);
    assign frame_start = active && (x_q == '0) && (y_q == '0);
    assign busy        = active;
    assign frame_count = fc_q;

    // Idle feeds inactive values so the delayed outputs fall PIPE_LAT cycles later.
    assign stage_in = {active && vs_win, active && hs_win, req_de};

    if (PIPE_LAT == 1) begin : g_pipe1
        assign pipe_d[0] = stage_in;
    end else begin : g_pipeN
        assign pipe_d = {pipe_q[PIPE_LAT-2:0], stage_in};
    end

    assign de    = pipe_q[PIPE_LAT-1][0];
    assign hsync = pipe_q[PIPE_LAT-1][1] ^ ~HS_POL;
    assign vsync = pipe_q[PIPE_LAT-1][2] ^ ~VS_POL;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        fc_d    = fc_q;
        if (state_q == S_IDLE) begin
            x_d = '0;
            y_d = '0;
            if (enable) begin
                state_d = S_RUN;
            end
        end else begin
            if (last_x) begin
                x_d = '0;
                if (last_y) begin
                    y_d  = '0;
                    fc_d = fc_q + FC_ONE;
                end else begin
                    y_d = y_q + CNT_ONE;
                end
            end else begin
                x_d = x_q + CNT_ONE;
            end
            // At the last pixel enable alone picks the next state, so a drain that
            // is re-enabled exactly there continues back-to-back instead of idling.
            if (last_x && last_y) begin
                state_d = enable ? S_RUN : S_IDLE;
            end else begin
                state_d = enable ? S_RUN : S_DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            fc_q    <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fc_q    <= fc_d;
            pipe_q  <= pipe_d;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, en_b;

    // Small configuration: H 4/1/2/1 (8), V 3/1/1/1 (6), PIPE_LAT 2, FC_W 2.
    logic [3:0] s_req_x, s_req_y;
    logic       s_req_de, s_line_start, s_frame_start, s_de, s_hsync, s_vsync, s_busy;
    logic [1:0] s_frame_count;

    // Default 640x480 configuration with FC_W 2.
    logic [9:0] d_req_x, d_req_y;
    logic       d_req_de, d_line_start, d_frame_start, d_de, d_hsync, d_vsync, d_busy;
    logic [1:0] d_frame_count;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_LAT(2), .CW(4), .FC_W(2)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .enable(en),
        .req_x(s_req_x), .req_y(s_req_y), .req_de(s_req_de),
        .line_start(s_line_start), .frame_start(s_frame_start),
        .de(s_de), .hsync(s_hsync), .vsync(s_vsync),
        .frame_count(s_frame_count), .busy(s_busy)
    );

    video_timing_gen #(
        .FC_W(2)
    ) u_dflt (
        .clk(clk), .rst_n(rst_n), .enable(en_b),
        .req_x(d_req_x), .req_y(d_req_y), .req_de(d_req_de),
        .line_start(d_line_start), .frame_start(d_frame_start),
        .de(d_de), .hsync(d_hsync), .vsync(d_vsync),
        .frame_count(d_frame_count), .busy(d_busy)
    );

    int checks   = 0;
    int failures = 0;

    // Expected {vsync, hsync, de} one and two cycles ago (small instance).
    logic [2:0] hist0, hist1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the small instance at the current sample point.
    // run: generator expected active; ph: cycle index within frame (0..47).
    task automatic step(input bit run, input int ph, input int fc);
        int x, y;
        bit rde, hsw, vsw;
        x   = run ? ph % 8 : 0;
        y   = run ? ph / 8 : 0;
        rde = run && (x < 4) && (y < 3);
        hsw = run && (x == 5 || x == 6);
        vsw = run && (y == 4);
        chk("req_x", s_req_x, x);
        chk("req_y", s_req_y, y);
        chk("req_de", s_req_de, rde);
        chk("line_start", s_line_start, run && x == 0);
        chk("frame_start", s_frame_start, run && ph == 0);
        chk("busy", s_busy, run);
        chk("frame_count", s_frame_count, fc);
        chk("de", s_de, hist1[0]);
        chk("hsync", s_hsync, hist1[1]);
        chk("vsync", s_vsync, hist1[2]);
        hist1 = hist0;
        hist0 = {vsw, hsw, rde};
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        en_b  = 1'b0;
        hist0 = '0;
        hist1 = '0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin step(0, 0, 0); tick(); end

        // Continuous run, two frames.
        step(0, 0, 0); en = 1'b1; tick();
        for (int t = 0; t < 96; t++) begin step(1, t % 48, (t / 48) % 4); tick(); end

        // Drain: enable drops at (0,1), frame finishes, then idle.
        for (int t = 96; t < 144; t++) begin
            step(1, t % 48, 2);
            if (t == 104) en = 1'b0;
            tick();
        end
        for (int i = 0; i < 10; i++) begin step(0, 0, 3); tick(); end

        // Resume mid-drain, frames continue; frame_count wraps 3->0;
        // enable dropped on the last-pixel cycle still counts that frame.
        step(0, 0, 3); en = 1'b1; tick();
        for (int u = 0; u < 144; u++) begin
            step(1, u % 48, (3 + u / 48) % 4);
            if (u == 8)   en = 1'b0;
            if (u == 24)  en = 1'b1;
            if (u == 143) en = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin step(0, 0, 2); tick(); end

        // One-cycle enable pulse still yields a full frame.
        step(0, 0, 2); en = 1'b1; tick();
        step(1, 0, 2); en = 1'b0; tick();
        for (int u = 1; u < 48; u++) begin step(1, u, 2); tick(); end
        for (int i = 0; i < 4; i++) begin step(0, 0, 3); tick(); end

        // Reset mid-frame at (2,1): everything inactive immediately.
        step(0, 0, 3); en = 1'b1; tick();
        for (int u = 0; u < 10; u++) begin step(1, u, 3); tick(); end
        chk("pre_rst_x", s_req_x, 2);
        chk("pre_rst_y", s_req_y, 1);
        chk("pre_rst_de", s_de, 1);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("rst_de", s_de, 0);
        chk("rst_hsync", s_hsync, 0);
        chk("rst_vsync", s_vsync, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_fc", s_frame_count, 0);
        chk("rst_x", s_req_x, 0);
        chk("rst_y", s_req_y, 0);
        chk("rst_req_de", s_req_de, 0);
        chk("rst_line_start", s_line_start, 0);
        chk("rst_frame_start", s_frame_start, 0);
        hist0 = '0;
        hist1 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin step(0, 0, 0); tick(); end

        // Default configuration, first line and start of the second.
        chk("d_idle_busy", d_busy, 0);
        chk("d_idle_hsync", d_hsync, 0);
        en_b = 1'b1;
        tick();
        for (int s = 0; s <= 801; s++) begin
            case (s)
                0: begin
                    chk("d_frame_start", d_frame_start, 1);
                    chk("d_req_de0", d_req_de, 1);
                    chk("d_busy", d_busy, 1);
                end
                1:   chk("d_de1", d_de, 1);
                640: chk("d_de640", d_de, 1);
                641: chk("d_de641", d_de, 0);
                656: chk("d_hs656", d_hsync, 0);
                657: chk("d_hs657", d_hsync, 1);
                752: chk("d_hs752", d_hsync, 1);
                753: begin
                    chk("d_hs753", d_hsync, 0);
                    chk("d_vs753", d_vsync, 0);
                end
                799: chk("d_x799", d_req_x, 799);
                800: begin
                    chk("d_x800", d_req_x, 0);
                    chk("d_y800", d_req_y, 1);
                    chk("d_ls800", d_line_start, 1);
                    chk("d_fs800", d_frame_start, 0);
                    chk("d_fc800", d_frame_count, 0);
                end
                default: ;
            endcase
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
